proc_multi: RTL

Parametrised successor to the team's 4-register, 8-bit bus processor.
- Multicycle datapath: NREG general registers, accumulator A and result register G, all on one shared internal bus.
- Executes eight-opcode instructions: moves, arithmetic, logic, NOP.
- Adds Zero/Carry flags and a Busy indication.
- Sits under the testbench/controller that drives Data and instruction fields with a w start strobe.

---
 rtl/proc_multi_pkg.sv | 26 ++
 rtl/proc_multi_alu.sv | 35 +++
 rtl/proc_multi.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/proc_multi_pkg.sv
// Shared opcode and step encodings for the multicycle bus processor.
package proc_multi_pkg;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOP = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  function automatic logic is_alu(opcode_t op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  endfunction

endpackage

// File: rtl/proc_multi_alu.sv
// Combinational ALU: arithmetic at WIDTH+1 bits so bit WIDTH is carry (add) or borrow (sub).
module proc_multi_alu
  import proc_multi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  opcode_t          op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o
);

  logic [WIDTH:0] wide;

  // NOTE: combinational blocks use blocking '=' and assign a default first,
  // so every path drives every output and no latch is inferred.
  always_comb begin
    wide = '0;
    unique case (op_i)
      OP_ADD:  wide = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB:  wide = {1'b0, a_i} - {1'b0, b_i};
      OP_AND:  wide = {1'b0, a_i & b_i};
      OP_OR:   wide = {1'b0, a_i | b_i};
      OP_XOR:  wide = {1'b0, a_i ^ b_i};
      default: wide = '0;
    endcase
  end

  assign result_o = wide[WIDTH-1:0];
  assign carry_o  = wide[WIDTH];
  assign zero_o   = (wide[WIDTH-1:0] == '0);

endmodule

// File: rtl/proc_multi.sv
// Multicycle bus processor: NREG registers, A and G on one OR-muxed bus, T0..T3 step control.
module proc_multi
  import proc_multi_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREG  = 4,
  localparam int RSEL  = $clog2(NREG)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             w,
  input  logic [WIDTH-1:0] Data,
  input  logic [2:0]       Op,
  input  logic [RSEL-1:0]  Rx,
  input  logic [RSEL-1:0]  Ry,
  output logic [WIDTH-1:0] BusWires,
  output logic             Done,
  output logic             Busy,
  output logic             Zflag,
  output logic             Cflag
);

  typedef struct packed {
    opcode_t         op;
    logic [RSEL-1:0] rx;
    logic [RSEL-1:0] ry;
  } instr_t;

  step_t  step_q, step_d;
  instr_t ir_q, ir_d;
  logic   done_q, busy_q;

  logic [WIDTH-1:0] r_q [NREG];
  logic [WIDTH-1:0] a_q, g_q;
  logic             z_q, c_q;

  logic [NREG-1:0]  r_out, r_in;
  logic             din_out, g_out, a_in, g_in;
  logic [WIDTH-1:0] bus;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_zero;

  always_comb begin
    r_out   = '0;
    r_in    = '0;
    din_out = 1'b0;
    g_out   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    unique case (step_q)
      T0: ;
      T1: begin
        unique case (ir_q.op)
          OP_MV: begin
            r_out[ir_q.ry] = 1'b1;
            r_in[ir_q.rx]  = 1'b1;
          end
          OP_MVI: begin
            din_out       = 1'b1;
            r_in[ir_q.rx] = 1'b1;
          end
          OP_NOP: ;
          default: begin
            r_out[ir_q.rx] = 1'b1;
            a_in           = 1'b1;
          end
        endcase
      end
      T2: if (is_alu(ir_q.op)) begin
        r_out[ir_q.ry] = 1'b1;
        g_in           = 1'b1;
      end
      T3: if (is_alu(ir_q.op)) begin
        g_out         = 1'b1;
        r_in[ir_q.rx] = 1'b1;
      end
    endcase
  end

  // Selects are one-hot, so OR-ing the gated sources is a plain mux; idle bus reads 0.
  always_comb begin
    bus = '0;
    if (din_out) bus |= Data;
    if (g_out)   bus |= g_q;
    for (int i = 0; i < NREG; i++) begin
      if (r_out[i]) bus |= r_q[i];
    end
  end

  proc_multi_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i     (a_q),
    .b_i     (bus),
    .op_i    (ir_q.op),
    .result_o(alu_res),
    .carry_o (alu_carry),
    .zero_o  (alu_zero)
  );

  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    unique case (step_q)
      T0: if (w) begin
        step_d = T1;
        ir_d   = '{op: opcode_t'(Op), rx: Rx, ry: Ry};
      end
      T1: step_d = is_alu(ir_q.op) ? T2 : T0;
      T2: step_d = T3;
      T3: step_d = T0;
    endcase
  end

  // Done/Busy are registered from the next step so they line up with the step itself.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      done_q <= (step_d == T3) || (step_d == T1 && !is_alu(ir_d.op));
      busy_q <= (step_d != T0);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      a_q <= '0;
      g_q <= '0;
      z_q <= 1'b0;
      c_q <= 1'b0;
    end else begin
      if (a_in) a_q <= bus;
      if (g_in) begin
        g_q <= alu_res;
        z_q <= alu_zero;
        c_q <= alu_carry;
      end
    end
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    // NOTE: the register file is built from resettable flops, not a RAM, so that an
    // aborted instruction can never leave a partial write behind after Reset.
    always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)       r_q[i] <= '0;
      else if (r_in[i]) r_q[i] <= bus;
    end
  end

  assign BusWires = bus;
  assign Done     = done_q;
  assign Busy     = busy_q;
  assign Zflag    = z_q;
  assign Cflag    = c_q;

endmodule
